// File: rtl/addn_digit_serial.sv
// addn_digit_serial: digit-serial adder/subtractor.
// Operands are accepted in IDLE, then DIGIT bits are added per clock (least
// significant digit first) through a DIGIT-bit ripple slice. The result is
// held in DONE until the consumer takes it.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high only in IDLE and out_valid
// only in DONE. Both are decoded from the state register alone, so neither
// has a combinational path from any input. A result cannot be consumed and a
// new operation accepted on the same edge.
module addn_digit_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic [1:0]       dbg_state
);

    // Number of digit cycles per operation.
    localparam int N    = WIDTH / DIGIT;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

    // Reject parameter sets that do not split WIDTH into whole digits.
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("addn_digit_serial: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;      // B, already inverted for subtraction
    logic [WIDTH-1:0]  s_r;
    logic              carry;    // running carry between digits
    logic              c_r;
    logic              v_r;
    logic [CNTW-1:0]   cnt;

    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [DIGIT-1:0]  d_sum;
    logic              d_cout;   // carry out of the slice's top bit
    logic              d_cmsb;   // carry into the slice's top bit

    // Select the current digit of both captured operands.
    always_comb begin
        a_dig = a_r[int'(cnt) * DIGIT +: DIGIT];
        b_dig = b_r[int'(cnt) * DIGIT +: DIGIT];
    end

    // DIGIT-bit ripple slice; also exposes the carry into its top bit, which
    // on the last digit is the carry into bit WIDTH-1 needed for overflow.
    always_comb begin
        logic c;
        c      = carry;
        d_cmsb = carry;
        d_sum  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                d_cmsb = c;
            end
            d_sum[i] = a_dig[i] ^ b_dig[i] ^ c;
            c        = (a_dig[i] & b_dig[i]) | (c & (a_dig[i] ^ b_dig[i]));
        end
        d_cout = c;
    end

    // Control FSM and datapath registers. Subtraction is folded in at
    // capture time: B is inverted and the carry-in becomes ~cin, so RUN only
    // ever adds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            s_r   <= '0;
            carry <= 1'b0;
            c_r   <= 1'b0;
            v_r   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= A;
                        b_r   <= sub ? ~B : B;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_r[int'(cnt) * DIGIT +: DIGIT] <= d_sum;
                    carry <= d_cout;
                    if (cnt == LAST) begin
                        c_r   <= d_cout;
                        v_r   <= d_cmsb ^ d_cout;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign S         = s_r;
    assign C         = c_r;
    assign V         = v_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_addn_digit_serial.sv
// Bench for addn_digit_serial: directed cases and random traffic on a
// 16/4 instance, plus random traffic on several other WIDTH/DIGIT shapes.
// Accepted operations push their expected result into a queue; monitors pop
// and compare whenever a result appears.
module tb_addn_digit_serial;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // Returns {V, C, S[63:0]} for a w-bit operation, from plain arithmetic.
    function automatic logic [65:0] ref_model(input int w, input longint unsigned a,
                                              input longint unsigned b, input logic ci,
                                              input logic sb);
        longint unsigned mask, tot, s;
        logic am, bm, sm, c, v;
        mask = (64'd1 << w) - 64'd1;
        if (sb) tot = (a & mask) + (~b & mask) + (ci ? 64'd0 : 64'd1);
        else    tot = (a & mask) + (b & mask) + (ci ? 64'd1 : 64'd0);
        s  = tot & mask;
        c  = 1'((tot >> w) & 64'd1);
        am = 1'((a >> (w - 1)) & 64'd1);
        bm = 1'((b >> (w - 1)) & 64'd1);
        sm = 1'((s >> (w - 1)) & 64'd1);
        // add overflows when equal-signed operands give a different-signed
        // sum; subtract when opposite-signed operands do.
        v  = sb ? ((am != bm) && (sm != am)) : ((am == bm) && (sm != am));
        return {v, c, s};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- main DUT (16/4) ----------------
    localparam int MW = 16;
    localparam int MD = 4;
    localparam int MN = MW / MD;

    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [MW-1:0] A, B, S;
    logic          cin, sub, C, V;
    logic [1:0]    dbg_state;

    addn_digit_serial #(.WIDTH(MW), .DIGIT(MD)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .S(S), .C(C), .V(V), .dbg_state(dbg_state)
    );

    // Scoreboard for the main DUT.
    logic [MW+1:0] exp_q[$];
    int            acc_q[$];

    initial begin
        logic          seen;
        logic [MW+1:0] held;
        logic [65:0]   r;
        seen = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                acc_q.delete();
                seen = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!seen) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL main_unexpected: got result 0x%0h with empty queue", {V, C, S});
                        end else begin
                            chk("main_result", {V, C, S}, exp_q.pop_front());
                            chk("main_latency", 64'(cyc - acc_q.pop_front()), MN);
                        end
                        held = {V, C, S};
                        seen = 1'b1;
                    end else begin
                        chk("main_hold", {V, C, S}, held);
                    end
                    if (out_ready) seen = 1'b0;
                end
                if (in_valid && in_ready) begin
                    r = ref_model(MW, A, B, cin, sub);
                    exp_q.push_back({r[65:64], r[MW-1:0]});
                    acc_q.push_back(cyc + 1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All driver tasks start and end just after a rising edge.
    task automatic run_to_done(input logic [MW-1:0] a, input logic [MW-1:0] b,
                               input logic ci, input logic sb, output int lat);
        A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; they must not matter.
        in_valid = 1'b0;
        A = MW'($urandom()); B = MW'($urandom());
        cin = 1'($urandom()); sub = 1'($urandom());
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_ready_after"}, in_ready, 1'b1);
        chk({nm, "_valid_after"}, out_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_op(input string nm, input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic ci, input logic sb, input logic [MW-1:0] es,
                         input logic ec, input logic ev);
        int lat;
        run_to_done(a, b, ci, sb, lat);
        @(negedge clk);
        chk({nm, "_lat"}, lat, MN);
        chk({nm, "_S"}, S, es);
        chk({nm, "_C"}, C, ec);
        chk({nm, "_V"}, V, ev);
        @(posedge clk); #1;
        consume(nm);
    endtask

    // ---------------- other parameter shapes ----------------
    localparam int NCFG = 7;
    localparam int NOPS = 400;
    localparam int CFG_W [NCFG] = '{8, 8, 16, 16, 32, 32, 32};
    localparam int CFG_D [NCFG] = '{1, 4, 1, 16, 1, 4, 16};

    logic rst_g_n;
    logic gen_done [NCFG];

    initial begin
        rst_g_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_g_n = 1'b1;
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = CFG_W[g];
        localparam int D = CFG_D[g];
        localparam int N = W / D;

        logic         iv, ir, ov, orr, ci, sb, c_o, v_o;
        logic [W-1:0] a, b, s;
        logic [1:0]   st;

        addn_digit_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .rst_n(rst_g_n), .in_valid(iv), .in_ready(ir),
            .A(a), .B(b), .cin(ci), .sub(sb), .out_valid(ov),
            .out_ready(orr), .S(s), .C(c_o), .V(v_o), .dbg_state(st)
        );

        logic [W+1:0] exp_q[$];
        int           acc_q[$];
        int           accepted = 0;

        // Random driver: random valid/ready duty and operands every cycle.
        initial begin
            gen_done[g] = 1'b0;
            iv = 1'b0; orr = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0;
            wait (rst_g_n);
            @(posedge clk); #1;
            for (int k = 0; k < 60000 && accepted < NOPS; k++) begin
                iv  = ($urandom_range(0, 3) != 0);
                orr = ($urandom_range(0, 3) != 0);
                a   = W'($urandom());
                b   = W'($urandom());
                ci  = 1'($urandom());
                sb  = 1'($urandom());
                @(posedge clk); #1;
            end
            iv = 1'b0; orr = 1'b1;
            for (int k = 0; k < 200 && (exp_q.size() != 0 || ov); k++) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            checks++;
            if (accepted < NOPS || exp_q.size() != 0) begin
                errors++;
                $display("FAIL cfg_w%0d_d%0d_done: got %0d accepted, %0d pending, required %0d and 0",
                         W, D, accepted, exp_q.size(), NOPS);
            end
            gen_done[g] = 1'b1;
        end

        // Monitor / scoreboard for this shape.
        initial begin
            logic        seen;
            logic [W+1:0] held;
            logic [65:0] r;
            seen = 1'b0;
            held = '0;
            forever begin
                @(negedge clk);
                if (!rst_g_n) begin
                    exp_q.delete();
                    acc_q.delete();
                    seen = 1'b0;
                end else begin
                    if (ov) begin
                        if (!seen) begin
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL cfg_w%0d_d%0d_unexpected: got 0x%0h with empty queue",
                                         W, D, {v_o, c_o, s});
                            end else begin
                                chk($sformatf("cfg_w%0d_d%0d_result", W, D), {v_o, c_o, s}, exp_q.pop_front());
                                chk($sformatf("cfg_w%0d_d%0d_latency", W, D), 64'(cyc - acc_q.pop_front()), N);
                            end
                            held = {v_o, c_o, s};
                            seen = 1'b1;
                        end else begin
                            chk($sformatf("cfg_w%0d_d%0d_hold", W, D), {v_o, c_o, s}, held);
                        end
                        if (orr) seen = 1'b0;
                    end
                    if (iv && ir) begin
                        r = ref_model(W, a, b, ci, sb);
                        exp_q.push_back({r[65:64], r[W-1:0]});
                        acc_q.push_back(cyc + 1);
                        accepted++;
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int acc_t[3];
        int n;
        logic all_done;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_S", S, 16'h0000);
        chk("reset_C", C, 1'b0);
        chk("reset_V", V, 1'b0);
        @(posedge clk); #1;

        do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_borrow",16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_cin",   16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        do_op("add_cin",   16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Backpressure: result held, new requests ignored.
        run_to_done(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; out_ready = 1'b0;
            A = MW'($urandom()); B = MW'($urandom());
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_S", S, 16'h3333);
            chk("bp_CV", {C, V}, 2'b00);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        consume("bp");

        // Reset at the second RUN edge aborts the operation.
        A = 16'hAAAA; B = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;          // accept edge
        in_valid = 1'b0;
        @(posedge clk); #1;          // first RUN edge
        rst_n = 1'b0;
        @(posedge clk); #1;          // second RUN edge, sampled in reset
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_S", S, 16'h0000);
        chk("rst_mid_CV", {C, V}, 2'b00);
        @(posedge clk); #1;
        do_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Full throughput: accepts must be N+2 edges apart.
        in_valid = 1'b1; out_ready = 1'b1; n = 0;
        for (int k = 0; k < 80 && n < 3; k++) begin
            A = MW'($urandom()); B = MW'($urandom());
            cin = 1'($urandom()); sub = 1'($urandom());
            if (in_ready) begin
                acc_t[n] = cyc + 1;
                n++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("tput_accepts", n, 3);
        chk("tput_interval0", 64'(acc_t[1] - acc_t[0]), MN + 2);
        chk("tput_interval1", 64'(acc_t[2] - acc_t[1]), MN + 2);
        for (int k = 0; k < 50 && (exp_q.size() != 0 || out_valid); k++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;

        // Random traffic on the main DUT.
        for (int k = 0; k < 3000; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            A = MW'($urandom()); B = MW'($urandom());
            cin = 1'($urandom()); sub = 1'($urandom());
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 100 && (exp_q.size() != 0 || out_valid); k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("main_drain", exp_q.size(), 0);

        // Wait for the other shapes to finish.
        all_done = 1'b0;
        for (int k = 0; k < 80000 && !all_done; k++) begin
            all_done = 1'b1;
            for (int g = 0; g < NCFG; g++) if (!gen_done[g]) all_done = 1'b0;
            if (!all_done) @(posedge clk);
        end
        checks++;
        if (!all_done) begin
            errors++;
            $display("FAIL sweep_timeout: got unfinished shapes, required all finished");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
